// File: rtl/aib_link_pkg.sv
// Shared types and constants for the multi-channel AIB link controller.
// Holds the FSM state encoding, default timing values and a counter-width helper.
package aib_link_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_CALIB = 3'd1,
      WAIT_XFER  = 3'd2,
      STABLE     = 3'd3,
      UP         = 3'd4,
      RETRAIN    = 3'd5,
      FAIL       = 3'd6
   } link_state_e;

   localparam int DEF_NBR_CHNLS      = 24;
   localparam int DEF_ACTIVE_CHNLS   = 4;
   localparam int DEF_STABLE_CYCLES  = 16;
   localparam int DEF_TIMEOUT_CYCLES = 65535;
   localparam int DEF_RETRAIN_CYCLES = 8;
   localparam int DEF_MAX_RETRY      = 3;

   // Bits needed to hold 0..max_val; never narrower than one bit so MAX_RETRY=0 stays legal.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/aib_multi_chnl_link_ctrl_if.sv
// Status-in / online-out bundle between the PHY/calibration side (master) and the link controller (slave).
interface aib_multi_chnl_link_ctrl_if
   import aib_link_pkg::*;
#(
   parameter int NBR_CHNLS    = DEF_NBR_CHNLS,
   parameter int ACTIVE_CHNLS = DEF_ACTIVE_CHNLS,
   parameter int RETRY_W      = cnt_width(DEF_MAX_RETRY)
);

   logic                    link_en;
   logic                    calib_done;
   logic [NBR_CHNLS-1:0]    ms_tx_transfer_en;
   logic [NBR_CHNLS-1:0]    ms_rx_transfer_en;
   logic [NBR_CHNLS-1:0]    sl_tx_transfer_en;
   logic [NBR_CHNLS-1:0]    sl_rx_transfer_en;
   logic [NBR_CHNLS-1:0]    m_rx_align_done;
   logic [ACTIVE_CHNLS-1:0] tx_online;
   logic [ACTIVE_CHNLS-1:0] rx_online;
   logic                    link_up;
   logic                    link_fail;
   logic                    adapter_rst_req;
   link_state_e             link_state;
   logic [RETRY_W-1:0]      retry_cnt;
   logic [15:0]             drop_cnt;
   logic [ACTIVE_CHNLS-1:0] last_drop_mask;

   modport master (
      output link_en, calib_done, ms_tx_transfer_en, ms_rx_transfer_en,
             sl_tx_transfer_en, sl_rx_transfer_en, m_rx_align_done,
      input  tx_online, rx_online, link_up, link_fail, adapter_rst_req,
             link_state, retry_cnt, drop_cnt, last_drop_mask
   );

   modport slave (
      input  link_en, calib_done, ms_tx_transfer_en, ms_rx_transfer_en,
             sl_tx_transfer_en, sl_rx_transfer_en, m_rx_align_done,
      output tx_online, rx_online, link_up, link_fail, adapter_rst_req,
             link_state, retry_cnt, drop_cnt, last_drop_mask
   );

endinterface

// File: rtl/aib_link_chnl_qual.sv
// Per-channel readiness qualification: a channel is good only when all five status bits are set.
// Channels at or above ACTIVE_CHNLS are deliberately ignored.
module aib_link_chnl_qual
   import aib_link_pkg::*;
#(
   parameter int NBR_CHNLS    = DEF_NBR_CHNLS,
   parameter int ACTIVE_CHNLS = DEF_ACTIVE_CHNLS
) (
   input  logic [NBR_CHNLS-1:0]    ms_tx_transfer_en,
   input  logic [NBR_CHNLS-1:0]    ms_rx_transfer_en,
   input  logic [NBR_CHNLS-1:0]    sl_tx_transfer_en,
   input  logic [NBR_CHNLS-1:0]    sl_rx_transfer_en,
   input  logic [NBR_CHNLS-1:0]    m_rx_align_done,
   output logic                    all_good,
   output logic [ACTIVE_CHNLS-1:0] fail_mask
);

   logic [ACTIVE_CHNLS-1:0] chnl_good;

   assign chnl_good = ms_tx_transfer_en[ACTIVE_CHNLS-1:0] & ms_rx_transfer_en[ACTIVE_CHNLS-1:0] &
                      sl_tx_transfer_en[ACTIVE_CHNLS-1:0] & sl_rx_transfer_en[ACTIVE_CHNLS-1:0] &
                      m_rx_align_done[ACTIVE_CHNLS-1:0];
   assign all_good  = &chnl_good;
   assign fail_mask = ~chnl_good;

   generate
      if (ACTIVE_CHNLS < NBR_CHNLS) begin : g_upper
         logic unused_upper;
         assign unused_upper = ^{ms_tx_transfer_en[NBR_CHNLS-1:ACTIVE_CHNLS],
                                 ms_rx_transfer_en[NBR_CHNLS-1:ACTIVE_CHNLS],
                                 sl_tx_transfer_en[NBR_CHNLS-1:ACTIVE_CHNLS],
                                 sl_rx_transfer_en[NBR_CHNLS-1:ACTIVE_CHNLS],
                                 m_rx_align_done[NBR_CHNLS-1:ACTIVE_CHNLS]};
      end
   endgenerate

endmodule

// File: rtl/aib_multi_chnl_link_ctrl.sv
// Multi-channel AIB link bring-up controller: stability qualification, timeout, bounded retrain, terminal fail.
// Define AIB_LINK_STATS_EN to enable the drop_cnt / last_drop_mask statistics.
module aib_multi_chnl_link_ctrl
   import aib_link_pkg::*;
#(
   parameter int NBR_CHNLS      = DEF_NBR_CHNLS,
   parameter int ACTIVE_CHNLS   = DEF_ACTIVE_CHNLS,
   parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int RETRAIN_CYCLES = DEF_RETRAIN_CYCLES,
   parameter int MAX_RETRY      = DEF_MAX_RETRY
) (
   input logic clk,
   input logic rst,
   aib_multi_chnl_link_ctrl_if.slave lnk
);

   localparam int RETRY_W = cnt_width(MAX_RETRY);
   localparam int STB_W   = cnt_width(STABLE_CYCLES);
   localparam int TMR_W   = cnt_width((TIMEOUT_CYCLES > RETRAIN_CYCLES) ? TIMEOUT_CYCLES : RETRAIN_CYCLES);

   link_state_e             state_q, state_d;
   logic [TMR_W-1:0]        timer_q, timer_d;
   logic [STB_W-1:0]        stable_q, stable_d;
   logic [RETRY_W-1:0]      retry_q, retry_d;
   logic                    link_up_q, link_fail_q, adapter_rst_q, online_q;
   logic                    all_good, fault, timeout, retrain_done;
   logic [ACTIVE_CHNLS-1:0] fail_mask;

   aib_link_chnl_qual #(
      .NBR_CHNLS    (NBR_CHNLS),
      .ACTIVE_CHNLS (ACTIVE_CHNLS)
   ) u_qual (
      .ms_tx_transfer_en (lnk.ms_tx_transfer_en),
      .ms_rx_transfer_en (lnk.ms_rx_transfer_en),
      .sl_tx_transfer_en (lnk.sl_tx_transfer_en),
      .sl_rx_transfer_en (lnk.sl_rx_transfer_en),
      .m_rx_align_done   (lnk.m_rx_align_done),
      .all_good          (all_good),
      .fail_mask         (fail_mask)
   );

   // One timer serves both the bring-up timeout and the retrain pulse length.
   assign timeout      = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));
   assign retrain_done = (timer_q == TMR_W'(RETRAIN_CYCLES - 1));

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      stable_d = stable_q;
      retry_d  = retry_q;
      fault    = 1'b0;
      unique case (state_q)
         IDLE: begin
            state_d  = WAIT_CALIB;
            timer_d  = '0;
            stable_d = '0;
            retry_d  = '0;
         end
         WAIT_CALIB: begin
            if (timeout) begin
               fault = 1'b1;
            end else if (lnk.calib_done) begin
               state_d = WAIT_XFER;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         WAIT_XFER: begin
            if (timeout) begin
               fault = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
               if (all_good) begin
                  state_d  = STABLE;
                  stable_d = STB_W'(1);
               end
            end
         end
         // Timeout is checked first so it wins over reaching UP in the same cycle.
         STABLE: begin
            if (timeout) begin
               fault = 1'b1;
            end else begin
               timer_d = timer_q + TMR_W'(1);
               if (!all_good) begin
                  state_d  = WAIT_XFER;
                  stable_d = '0;
               end else if (stable_q == STB_W'(STABLE_CYCLES)) begin
                  state_d = UP;
               end else begin
                  stable_d = stable_q + STB_W'(1);
               end
            end
         end
         UP: begin
            fault = !all_good;
         end
         RETRAIN: begin
            if (retrain_done) begin
               state_d = WAIT_CALIB;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         FAIL: begin
            state_d = FAIL;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Retry budget is spent on entry, so an exhausted budget skips the reset pulse entirely.
      if (fault) begin
         if (retry_q == RETRY_W'(MAX_RETRY)) begin
            state_d = FAIL;
         end else begin
            state_d = RETRAIN;
            retry_d = retry_q + RETRY_W'(1);
            timer_d = '0;
         end
      end

      if (!lnk.link_en) begin
         state_d  = IDLE;
         timer_d  = '0;
         stable_d = '0;
         retry_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         stable_q      <= '0;
         retry_q       <= '0;
         link_up_q     <= 1'b0;
         link_fail_q   <= 1'b0;
         adapter_rst_q <= 1'b0;
         online_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         stable_q      <= stable_d;
         retry_q       <= retry_d;
         link_up_q     <= (state_d == UP);
         link_fail_q   <= (state_d == FAIL);
         adapter_rst_q <= (state_d == RETRAIN);
         online_q      <= (state_q == UP) && (state_d == UP);
      end
   end

   assign lnk.tx_online       = {ACTIVE_CHNLS{online_q}};
   assign lnk.rx_online       = {ACTIVE_CHNLS{online_q}};
   assign lnk.link_up         = link_up_q;
   assign lnk.link_fail       = link_fail_q;
   assign lnk.adapter_rst_req = adapter_rst_q;
   assign lnk.link_state      = state_q;
   assign lnk.retry_cnt       = retry_q;

`ifdef AIB_LINK_STATS_EN
   logic [15:0]             drop_cnt_q;
   logic [ACTIVE_CHNLS-1:0] last_drop_mask_q;

   // Statistics survive link_en toggles; only rst clears them.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q       <= '0;
         last_drop_mask_q <= '0;
      end else if ((state_q == UP) && (state_d == RETRAIN)) begin
         if (drop_cnt_q != 16'hFFFF) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
         end
         last_drop_mask_q <= fail_mask;
      end
   end

   assign lnk.drop_cnt       = drop_cnt_q;
   assign lnk.last_drop_mask = last_drop_mask_q;
`else
   logic unused_fail_mask;
   assign unused_fail_mask   = ^fail_mask;
   assign lnk.drop_cnt       = '0;
   assign lnk.last_drop_mask = '0;
`endif

endmodule
